// File: rtl/av2_mem_pkg.sv
// Shared definitions for the AV2 frame-buffer port arbiter.
//   state_t                 2-bit FSM encoding (IDLE, ISSUE, WAIT, RESP)
//   OP_RD / OP_WR           transaction direction as carried on req_we
//   DEFAULT_TIMEOUT_CYCLES  default WAIT bound before forced completion
package av2_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/av2_fb_port_arbiter_if.sv
// Bundle of all arbiter signals other than clk/rst_n.
//   req_*        requester side: valid/we/addr/wdata in, ready out
//   rsp_*        per-requester completion pulse, error flag, read data
//   fb_*         single-beat port toward the frame buffer controller
//   busy, grant_id, timeout_err, dbg_state   status and debug
// Modports: slave = the arbiter itself, master = requesters + frame buffer side.
//
// Handshake: a request transfers on a cycle where req_valid[i] & req_ready[i]
// are both high. Once req_valid[i] rises, req_we/addr/wdata[i] must hold until
// that cycle; req_ready never depends on anything but req_valid and arbiter
// state, so a requester may wait on it without a combinational loop.
interface av2_fb_port_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  import av2_mem_pkg::*;

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic                          rsp_err;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic [ADDR_WIDTH-1:0]         fb_wr_addr;
  logic [DATA_WIDTH-1:0]         fb_wr_data;
  logic                          fb_wr_en;
  logic [ADDR_WIDTH-1:0]         fb_rd_addr;
  logic                          fb_rd_en;
  logic [DATA_WIDTH-1:0]         fb_rd_data;
  logic                          fb_wr_done;
  logic                          fb_rd_done;
  logic                          busy;
  logic [IW-1:0]                 grant_id;
  logic                          timeout_err;
  state_t                        dbg_state;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, fb_rd_data, fb_wr_done, fb_rd_done,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, fb_wr_addr, fb_wr_data, fb_wr_en,
           fb_rd_addr, fb_rd_en, busy, grant_id, timeout_err, dbg_state
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, fb_rd_data, fb_wr_done, fb_rd_done,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, fb_wr_addr, fb_wr_data, fb_wr_en,
           fb_rd_addr, fb_rd_en, busy, grant_id, timeout_err, dbg_state
  );

endinterface

// File: rtl/av2_rr_arbiter.sv
// Combinational round-robin pick.
//   i_req        request vector
//   i_rr_ptr     index of the last winner; search starts at i_rr_ptr+1
//   o_grant      one-hot winner (all zero if no request)
//   o_grant_idx  binary index of the winner (0 if no request)
module av2_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_rr_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic          w_found;
  logic [IW-1:0] w_idx;

  // Walk rr_ptr+1 .. rr_ptr+NUM_REQ modulo NUM_REQ; the last winner is
  // visited last, which bounds any waiter to NUM_REQ-1 grants.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    w_found     = 1'b0;
    w_idx       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = IW'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!w_found && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/av2_fb_port_arbiter.sv
// Shares the single-beat frame buffer read/write port among NUM_REQ requesters.
// One transaction is outstanding at a time: IDLE -> ISSUE -> WAIT -> RESP.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          av2_fb_port_arbiter_if.slave (requests, responses, fb port, status)
module av2_fb_port_arbiter
  import av2_mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 128,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  rst_n,
  av2_fb_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state;
  state_t                w_state_n;
  logic [IW-1:0]         r_rr_ptr;
  logic [IW-1:0]         r_idx;
  logic [IW-1:0]         r_grant_id;
  logic                  r_we;
  logic                  r_err;
  logic                  r_timeout_err;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [CW-1:0]         r_cnt;
  logic [NUM_REQ-1:0]    w_grant;
  logic [IW-1:0]         w_gidx;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;

  av2_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req       (bus.req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_gidx)
  );

  // The arbiter always grants a valid requester, so any valid in IDLE is a handshake.
  assign w_accept  = (r_state == ST_IDLE) && (|bus.req_valid);
  // Only the done matching the latched direction counts; the other is ignored.
  assign w_done    = (r_we == OP_WR) ? bus.fb_wr_done : bus.fb_rd_done;
  assign w_timeout = (r_cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_n = ST_ISSUE;
      ST_ISSUE: w_state_n = ST_WAIT;
      ST_WAIT:  if (w_done || w_timeout) w_state_n = ST_RESP;
      ST_RESP:  w_state_n = ST_IDLE;
      default:  w_state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.fb_wr_en  = 1'b0;
    bus.fb_rd_en  = 1'b0;
    bus.rsp_valid = '0;
    bus.rsp_err   = 1'b0;
    bus.rsp_rdata = '0;
    unique case (r_state)
      ST_IDLE:  bus.req_ready = w_grant;
      ST_ISSUE: begin
        bus.fb_wr_en = (r_we == OP_WR);
        bus.fb_rd_en = (r_we == OP_RD);
      end
      ST_RESP: begin
        bus.rsp_valid[r_idx] = 1'b1;
        bus.rsp_err          = r_err;
        // fb_rd_data was registered by the controller on the done edge.
        if ((r_we == OP_RD) && !r_err) bus.rsp_rdata = bus.fb_rd_data;
      end
      default: ;
    endcase
  end

  // Address/data stay latched from accept until the next accept, because the
  // controller samples wr_data late (after awready).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr      <= IW'(NUM_REQ - 1);
      r_idx         <= '0;
      r_grant_id    <= '0;
      r_we          <= OP_RD;
      r_err         <= 1'b0;
      r_timeout_err <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_cnt         <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_idx      <= w_gidx;
            r_rr_ptr   <= w_gidx;
            r_grant_id <= w_gidx;
            r_we       <= bus.req_we[w_gidx];
            r_addr     <= bus.req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata    <= bus.req_wdata[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
            r_err      <= 1'b0;
          end
        end
        ST_ISSUE: r_cnt <= '0;
        ST_WAIT: begin
          // Done beats the timeout when both land in the same cycle.
          if (!w_done) begin
            if (w_timeout) begin
              r_err         <= 1'b1;
              r_timeout_err <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;
  assign bus.fb_wr_addr  = r_addr;
  assign bus.fb_rd_addr  = r_addr;
  assign bus.fb_wr_data  = r_wdata;
  assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_av2_fb_port_arbiter.sv
`timescale 1ns/1ps
module tb_av2_fb_port_arbiter;
  import av2_mem_pkg::*;

  localparam int NR       = 4;
  localparam int AW       = 32;
  localparam int DW       = 128;
  localparam int TO_LONG  = 64;
  localparam int TO_SHORT = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  av2_fb_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  av2_fb_port_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_t ();

  av2_fb_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_LONG))
    u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  av2_fb_port_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO_SHORT))
    u_dut_to (.clk(clk), .rst_n(rst_n), .bus(bus_t));

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid    = '0; bus.req_we    = '0; bus.req_addr    = '0; bus.req_wdata    = '0;
    bus.fb_rd_data   = '0; bus.fb_wr_done = 1'b0; bus.fb_rd_done = 1'b0;
    bus_t.req_valid  = '0; bus_t.req_we  = '0; bus_t.req_addr  = '0; bus_t.req_wdata  = '0;
    bus_t.fb_rd_data = '0; bus_t.fb_wr_done = 1'b0; bus_t.fb_rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.busy, bus.fb_wr_en, bus.fb_rd_en, bus.rsp_err, bus.timeout_err} !== 5'b0) begin
      failures++;
      $display("FAIL rst_flags got=%b exp=00000",
               {bus.busy, bus.fb_wr_en, bus.fb_rd_en, bus.rsp_err, bus.timeout_err});
    end
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.grant_id} !== 10'b0) begin
      failures++;
      $display("FAIL rst_vec ready=%b rsp=%b gid=%0d exp=0", bus.req_ready, bus.rsp_valid, bus.grant_id);
    end
    checks++;
    if (bus.fb_wr_addr !== '0 || bus.fb_rd_addr !== '0 || bus.fb_wr_data !== '0 || bus.rsp_rdata !== '0) begin
      failures++;
      $display("FAIL rst_bus wa=%h ra=%h wd=%h rd=%h exp=0", bus.fb_wr_addr, bus.fb_rd_addr,
               bus.fb_wr_data, bus.rsp_rdata);
    end
    checks++;
    if (bus.dbg_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_state got=%0d exp=%0d", bus.dbg_state, ST_IDLE);
    end
    bus.req_valid = 4'b1000;
    #1;
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rst_ready_single got=%b exp=1000", bus.req_ready);
    end
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rst_ready_all got=%b exp=0001", bus.req_ready);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_single_read();
    logic [DW-1:0] d1;
    int en_cnt;
    d1 = {4{32'hDEAD_BEEF}};
    do_reset();
    bus.req_addr[0 +: AW] = 32'h100;
    bus.req_valid = 4'b0001;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rd_ready got=%b exp=0001", bus.req_ready);
    end
    step();  // ISSUE
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.fb_rd_en !== 1'b1 || bus.fb_wr_en !== 1'b0 || bus.fb_rd_addr !== 32'h100) begin
      failures++;
      $display("FAIL rd_issue rd_en=%b wr_en=%b addr=%h exp=1,0,100", bus.fb_rd_en, bus.fb_wr_en, bus.fb_rd_addr);
    end
    checks++;
    if (bus.grant_id !== 2'd0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_gid gid=%0d busy=%b exp=0,1", bus.grant_id, bus.busy);
    end
    en_cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (bus.fb_rd_en === 1'b1) en_cnt++;
      if (c == 5) begin
        bus.fb_rd_done = 1'b1;
        bus.fb_rd_data = d1;
      end
    end
    checks++;
    if (en_cnt !== 0) begin
      failures++;
      $display("FAIL rd_en_pulse extra_cycles=%0d exp=0", en_cnt);
    end
    step();  // RESP
    bus.fb_rd_done = 1'b0;
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== d1) begin
      failures++;
      $display("FAIL rd_rsp rsp=%b err=%b data=%h exp=0001,0,%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, d1);
    end
    step();
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle rsp=%b busy=%b exp=0000,0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_round_robin();
    int exp_order[5];
    logic [AW-1:0] addr_of[NR];
    int n, last_c, rsp_cnt;
    logic pend;
    exp_order = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NR; i++) begin
      addr_of[i] = 32'h1000 + 32'(i * 16);
      bus.req_addr[i*AW +: AW] = addr_of[i];
    end
    bus.req_valid = 4'b1111;
    n = 0; last_c = 0; rsp_cnt = 0; pend = 1'b0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      step();
      bus.fb_rd_done = 1'b0;
      if (pend) begin
        bus.fb_rd_done = 1'b1;
        pend = 1'b0;
      end
      if (bus.rsp_valid !== 4'b0000 && n > 0) begin
        rsp_cnt++;
        checks++;
        if (bus.rsp_valid !== (4'b0001 << exp_order[n-1])) begin
          failures++;
          $display("FAIL rr_rsp got=%b exp_req=%0d", bus.rsp_valid, exp_order[n-1]);
        end
      end
      if (bus.fb_rd_en === 1'b1) begin
        checks++;
        if (int'(bus.grant_id) != exp_order[n] || bus.fb_rd_addr !== addr_of[exp_order[n]]) begin
          failures++;
          $display("FAIL rr_grant n=%0d gid=%0d addr=%h exp=%0d", n, bus.grant_id, bus.fb_rd_addr, exp_order[n]);
        end
        if (n > 0) begin
          checks++;
          if (c - last_c != 4) begin
            failures++;
            $display("FAIL rr_spacing n=%0d got=%0d exp=4", n, c - last_c);
          end
        end
        last_c = c;
        n++;
        pend = 1'b1;
      end
    end
    checks++;
    if (n != 5 || rsp_cnt != 4) begin
      failures++;
      $display("FAIL rr_count grants=%0d rsps=%0d exp=5,4", n, rsp_cnt);
    end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_write_hold();
    logic [DW-1:0] wd;
    int bad;
    wd = {16{8'hA5}};
    do_reset();
    bus.fb_rd_data = {4{32'h1234_5678}};
    bus.req_we = 4'b0100;
    bus.req_addr[2*AW +: AW] = 32'h40;
    bus.req_wdata[2*DW +: DW] = wd;
    bus.req_valid = 4'b0100;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL wr_ready got=%b exp=0100", bus.req_ready);
    end
    step();  // ISSUE
    bus.req_valid = 4'b0000;
    bus.req_addr  = '1;
    bus.req_wdata = '1;
    checks++;
    if (bus.fb_wr_en !== 1'b1 || bus.fb_rd_en !== 1'b0 || bus.fb_wr_addr !== 32'h40 || bus.fb_wr_data !== wd) begin
      failures++;
      $display("FAIL wr_issue wr_en=%b rd_en=%b addr=%h data=%h", bus.fb_wr_en, bus.fb_rd_en,
               bus.fb_wr_addr, bus.fb_wr_data);
    end
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      checks++;
      if (bus.fb_wr_addr !== 32'h40 || bus.fb_wr_data !== wd || bus.fb_wr_en !== 1'b0 || bus.rsp_valid !== 4'b0) begin
        failures++;
        bad++;
        if (bad < 4)
          $display("FAIL wr_hold c=%0d addr=%h data=%h en=%b rsp=%b", c, bus.fb_wr_addr, bus.fb_wr_data,
                   bus.fb_wr_en, bus.rsp_valid);
      end
      if (c == 20) bus.fb_wr_done = 1'b1;
    end
    step();  // RESP
    bus.fb_wr_done = 1'b0;
    checks++;
    if (bus.rsp_valid !== 4'b0100 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== '0) begin
      failures++;
      $display("FAIL wr_rsp rsp=%b err=%b data=%h exp=0100,0,0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.fb_wr_addr !== 32'h40 || bus.grant_id !== 2'd2) begin
      failures++;
      $display("FAIL wr_after busy=%b addr=%h gid=%0d exp=0,40,2", bus.busy, bus.fb_wr_addr, bus.grant_id);
    end
  endtask

  task automatic test_timeout();
    logic [DW-1:0] dt;
    logic seen;
    int rsp_c;
    dt = {4{32'hCAFE_F00D}};
    do_reset();
    bus_t.fb_rd_data = dt;
    bus_t.req_addr[1*AW +: AW] = 32'h200;
    bus_t.req_valid = 4'b0010;
    step();  // ISSUE
    bus_t.req_valid = 4'b0000;
    checks++;
    if (bus_t.fb_rd_en !== 1'b1 || bus_t.fb_rd_addr !== 32'h200) begin
      failures++;
      $display("FAIL to_issue rd_en=%b addr=%h exp=1,200", bus_t.fb_rd_en, bus_t.fb_rd_addr);
    end
    // 16 WAIT cycles, then RESP on the 17th cycle after ISSUE.
    seen = 1'b0;
    rsp_c = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      step();
      if (bus_t.rsp_valid !== 4'b0000) begin
        seen = 1'b1;
        rsp_c = c;
        checks++;
        if (bus_t.rsp_valid !== 4'b0010 || bus_t.rsp_err !== 1'b1 || bus_t.rsp_rdata !== '0) begin
          failures++;
          $display("FAIL to_rsp rsp=%b err=%b data=%h exp=0010,1,0", bus_t.rsp_valid, bus_t.rsp_err, bus_t.rsp_rdata);
        end
      end
    end
    checks++;
    if (!seen || rsp_c != 17) begin
      failures++;
      $display("FAIL to_latency seen=%b cycles=%0d exp=17", seen, rsp_c);
    end
    step();
    checks++;
    if (bus_t.timeout_err !== 1'b1 || bus_t.busy !== 1'b0) begin
      failures++;
      $display("FAIL to_sticky terr=%b busy=%b exp=1,0", bus_t.timeout_err, bus_t.busy);
    end
    bus_t.req_addr[2*AW +: AW] = 32'h300;
    bus_t.req_valid = 4'b0100;
    step();  // ISSUE
    bus_t.req_valid = 4'b0000;
    checks++;
    if (bus_t.grant_id !== 2'd2 || bus_t.fb_rd_en !== 1'b1 || bus_t.fb_rd_addr !== 32'h300) begin
      failures++;
      $display("FAIL to_next_issue gid=%0d en=%b addr=%h exp=2,1,300", bus_t.grant_id, bus_t.fb_rd_en, bus_t.fb_rd_addr);
    end
    step();  // WAIT
    bus_t.fb_rd_done = 1'b1;
    step();  // RESP
    bus_t.fb_rd_done = 1'b0;
    checks++;
    if (bus_t.rsp_valid !== 4'b0100 || bus_t.rsp_err !== 1'b0 || bus_t.rsp_rdata !== dt || bus_t.timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL to_next_rsp rsp=%b err=%b data=%h terr=%b", bus_t.rsp_valid, bus_t.rsp_err,
               bus_t.rsp_rdata, bus_t.timeout_err);
    end
    step();
  endtask

  task automatic test_collisions();
    logic [DW-1:0] dc;
    dc = {4{32'h0BAD_CAFE}};
    do_reset();
    // done on the 16th WAIT cycle, the same cycle the counter hits its limit
    bus_t.fb_rd_data = dc;
    bus_t.req_addr[3*AW +: AW] = 32'h400;
    bus_t.req_valid = 4'b1000;
    step();  // ISSUE
    bus_t.req_valid = 4'b0000;
    for (int c = 1; c <= 16; c++) begin
      step();
      if (c == 16) begin
        checks++;
        if (bus_t.rsp_valid !== 4'b0000 || bus_t.busy !== 1'b1) begin
          failures++;
          $display("FAIL col_early rsp=%b busy=%b exp=0000,1", bus_t.rsp_valid, bus_t.busy);
        end
        bus_t.fb_rd_done = 1'b1;
      end
    end
    step();  // RESP
    bus_t.fb_rd_done = 1'b0;
    checks++;
    if (bus_t.rsp_valid !== 4'b1000 || bus_t.rsp_err !== 1'b0 || bus_t.rsp_rdata !== dc || bus_t.timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL col_done_wins rsp=%b err=%b data=%h terr=%b exp=1000,0,%h,0", bus_t.rsp_valid,
               bus_t.rsp_err, bus_t.rsp_rdata, bus_t.timeout_err, dc);
    end
    // a write-done during a read must be ignored
    bus.fb_rd_data = dc;
    bus.req_addr[0 +: AW] = 32'h500;
    bus.req_valid = 4'b0001;
    step();  // ISSUE
    bus.req_valid = 4'b0000;
    step();  // WAIT 1
    bus.fb_wr_done = 1'b1;
    step();  // WAIT 2
    bus.fb_wr_done = 1'b0;
    checks++;
    if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL col_wrdone_ignored rsp=%b busy=%b exp=0000,1", bus.rsp_valid, bus.busy);
    end
    bus.fb_rd_done = 1'b1;
    step();  // RESP
    bus.fb_rd_done = 1'b0;
    checks++;
    if (bus.rsp_valid !== 4'b0001 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== dc) begin
      failures++;
      $display("FAIL col_rd_rsp rsp=%b err=%b data=%h exp=0001,0,%h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, dc);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    bus.req_addr[0 +: AW]  = 32'h10;
    bus.req_addr[AW +: AW] = 32'h300;
    bus.req_valid = 4'b0010;
    step();  // ISSUE
    bus.req_valid = 4'b0000;
    step();  // WAIT
    checks++;
    if (bus.busy !== 1'b1 || bus.fb_rd_addr !== 32'h300 || bus.grant_id !== 2'd1) begin
      failures++;
      $display("FAIL rw_pre busy=%b addr=%h gid=%0d exp=1,300,1", bus.busy, bus.fb_rd_addr, bus.grant_id);
    end
    #2;
    rst_n = 1'b0;  // mid-cycle, away from any clock edge
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.fb_rd_addr !== '0 || bus.grant_id !== '0 || bus.rsp_valid !== '0 ||
        bus.fb_rd_en !== 1'b0 || bus.req_ready !== '0) begin
      failures++;
      $display("FAIL rw_async busy=%b addr=%h gid=%0d rsp=%b en=%b rdy=%b exp=all0", bus.busy,
               bus.fb_rd_addr, bus.grant_id, bus.rsp_valid, bus.fb_rd_en, bus.req_ready);
    end
    step();
    rst_n = 1'b1;
    bus.req_valid = 4'b1111;
    #1;
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL rw_ready got=%b exp=0001", bus.req_ready);
    end
    step();  // ISSUE
    bus.req_valid = 4'b0000;
    checks++;
    if (bus.grant_id !== 2'd0 || bus.fb_rd_en !== 1'b1 || bus.fb_rd_addr !== 32'h10) begin
      failures++;
      $display("FAIL rw_grant gid=%0d en=%b addr=%h exp=0,1,10", bus.grant_id, bus.fb_rd_en, bus.fb_rd_addr);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_hold();
    test_timeout();
    test_collisions();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
